// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  localparam int SERIAL_ADD_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a producer of operands and serial_add.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int N = SERIAL_ADD_N
) ();

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_add_bit_fa.sv
// Combinational one-bit full adder used as the serial adder's bit cell.
module bit_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add.sv
// Bit-serial N-bit adder: one bit per clock LSB first, result held until the next run.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int N = SERIAL_ADD_N
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus
);

  localparam int CW = $clog2(N);

  state_t         state_reg;
  logic [N-1:0]   sa_reg;
  logic [N-1:0]   sb_reg;
  logic [N-1:0]   res_reg;
  logic [N-1:0]   sum_reg;
  logic [CW-1:0]  cnt_reg;
  logic           carry_reg;
  logic           cout_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           fa_s;
  logic           fa_co;
  logic [N-1:0]   res_next;
`ifdef SERIAL_ADD_OVF_EN
  logic           ovf_reg;
`endif

  bit_fa u_fa (
    .x  (sa_reg[0]),
    .y  (sb_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after N shifts bit 0 sits at the LSB.
  assign res_next = {fa_s, res_reg[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            sa_reg    <= bus.a;
            sb_reg    <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= fa_co;
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            // Outputs change only here, so consumers never see partial sums.
            sum_reg   <= res_next;
            cout_reg  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg   <= carry_reg ^ fa_co;
`endif
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_reg;
`endif

endmodule
